// File: rtl/ins_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : ins_fetcher
// Brief    : Instruction-fetch stage. Holds the PC, fetches one 32-bit word
//            at a time from the instruction cache, pre-decodes control flow,
//            queries the branch predictor for conditional branches and hands
//            one instruction per handshake to the decoder. Redirects on
//            predictor flush or JALR resolution.
// Revision : 1.0 - initial release
// ============================================================================
module ins_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_rdy,
    input  logic [31:0] icache_ins,
    output logic        ask_predictor,
    output logic [31:0] now_ins_addr,
    output logic [31:0] jump_addr_from_if,
    output logic [31:0] next_addr_from_if,
    input  logic        jump,
    input  logic        predictor_sgn_rdy,
    input  logic        predictor_full,
    input  logic        if_flush,
    input  logic [31:0] addr_to_if,
    input  logic        jalr_done,
    input  logic [31:0] jalr_target,
    input  logic        dec_full,
    output logic        ins_valid,
    output logic [31:0] ins_out,
    output logic [31:0] ins_pc,
    output logic        ins_pred_jump
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_WAIT_IC   = 3'd1,
        S_ASK       = 3'd2,
        S_WAIT_PRED = 3'd3,
        S_ISSUE     = 3'd4,
        S_WAIT_JALR = 3'd5
    } state_t;

    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;

    state_t      r_state,        w_state;
    logic [31:0] r_pc,           w_pc;
    logic [31:0] r_npc,          w_npc;
    logic [31:0] r_ins,          w_ins;
    logic        r_pred,         w_pred;
    logic        r_is_jalr,      w_is_jalr;
    logic        r_drop,         w_drop;
    logic        r_icache_req,   w_icache_req;
    logic [31:0] r_icache_addr,  w_icache_addr;
    logic        r_ask,          w_ask;
    logic [31:0] r_now_addr,     w_now_addr;
    logic [31:0] r_jump_addr,    w_jump_addr;
    logic [31:0] r_next_addr,    w_next_addr;
    logic        r_ins_valid,    w_ins_valid;
    logic [31:0] r_ins_out,      w_ins_out;
    logic [31:0] r_ins_pc,       w_ins_pc;
    logic        r_ins_pred,     w_ins_pred;

    // J-immediate comes from the word arriving from the cache (decoded on
    // arrival); B-immediate from the latched word (used in ASK/WAIT_PRED).
    logic [31:0] w_j_imm;
    logic [31:0] w_b_imm;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;

    assign w_j_imm     = {{12{icache_ins[31]}}, icache_ins[19:12], icache_ins[20],
                          icache_ins[30:21], 1'b0};
    assign w_b_imm     = {{20{r_ins[31]}}, r_ins[7], r_ins[30:25], r_ins[11:8], 1'b0};
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_target = r_pc + w_b_imm;

    // Next-state and next-output computation; everything holds while rdy=0
    always_comb begin
        w_state       = r_state;
        w_pc          = r_pc;
        w_npc         = r_npc;
        w_ins         = r_ins;
        w_pred        = r_pred;
        w_is_jalr     = r_is_jalr;
        w_drop        = r_drop;
        w_icache_req  = r_icache_req;
        w_icache_addr = r_icache_addr;
        w_ask         = r_ask;
        w_now_addr    = r_now_addr;
        w_jump_addr   = r_jump_addr;
        w_next_addr   = r_next_addr;
        w_ins_valid   = r_ins_valid;
        w_ins_out     = r_ins_out;
        w_ins_pc      = r_ins_pc;
        w_ins_pred    = r_ins_pred;

        if (rdy) begin
            // Query and issue strobes are single-cycle pulses
            w_ask       = 1'b0;
            w_ins_valid = 1'b0;

            if (if_flush) begin
                w_pc         = addr_to_if;
                w_state      = S_FETCH;
                w_icache_req = 1'b0;
                w_is_jalr    = 1'b0;
                w_pred       = 1'b0;
                // A request still outstanding at the cache will answer later;
                // that answer belongs to the old path and must be swallowed.
                if (r_state == S_WAIT_IC && !icache_rdy) begin
                    w_drop = 1'b1;
                end else if (r_state == S_FETCH && r_drop && icache_rdy) begin
                    w_drop = 1'b0;
                end
            end else begin
                case (r_state)
                    S_FETCH: begin
                        if (r_drop) begin
                            if (icache_rdy) begin
                                w_drop = 1'b0;
                            end
                        end else if (!dec_full) begin
                            w_icache_req  = 1'b1;
                            w_icache_addr = r_pc;
                            w_state       = S_WAIT_IC;
                        end
                    end
                    S_WAIT_IC: begin
                        if (icache_rdy) begin
                            w_icache_req = 1'b0;
                            w_ins        = icache_ins;
                            w_is_jalr    = 1'b0;
                            w_pred       = 1'b0;
                            w_state      = S_ISSUE;
                            case (icache_ins[6:0])
                                c_OP_BRANCH: w_state   = S_ASK;
                                c_OP_JAL: begin
                                    w_pred = 1'b1;
                                    w_npc  = r_pc + w_j_imm;
                                end
                                c_OP_JALR:   w_is_jalr = 1'b1;
                                default:     w_npc     = w_pc_plus4;
                            endcase
                        end
                    end
                    S_ASK: begin
                        if (!predictor_full) begin
                            w_ask       = 1'b1;
                            w_now_addr  = r_pc;
                            w_jump_addr = w_br_target;
                            w_next_addr = w_pc_plus4;
                            w_state     = S_WAIT_PRED;
                        end
                    end
                    S_WAIT_PRED: begin
                        if (predictor_sgn_rdy) begin
                            w_pred  = jump;
                            w_npc   = jump ? w_br_target : w_pc_plus4;
                            w_state = S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (!dec_full) begin
                            w_ins_valid = 1'b1;
                            w_ins_out   = r_ins;
                            w_ins_pc    = r_pc;
                            w_ins_pred  = r_pred;
                            if (r_is_jalr) begin
                                w_state = S_WAIT_JALR;
                            end else begin
                                w_pc    = r_npc;
                                w_state = S_FETCH;
                            end
                        end
                    end
                    S_WAIT_JALR: begin
                        if (jalr_done) begin
                            w_pc      = jalr_target;
                            w_is_jalr = 1'b0;
                            w_state   = S_FETCH;
                        end
                    end
                    default: w_state = S_FETCH;
                endcase
            end
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_npc         <= 32'h0;
            r_ins         <= 32'h0;
            r_pred        <= 1'b0;
            r_is_jalr     <= 1'b0;
            r_drop        <= 1'b0;
            r_icache_req  <= 1'b0;
            r_icache_addr <= 32'h0;
            r_ask         <= 1'b0;
            r_now_addr    <= 32'h0;
            r_jump_addr   <= 32'h0;
            r_next_addr   <= 32'h0;
            r_ins_valid   <= 1'b0;
            r_ins_out     <= 32'h0;
            r_ins_pc      <= 32'h0;
            r_ins_pred    <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_pc          <= w_pc;
            r_npc         <= w_npc;
            r_ins         <= w_ins;
            r_pred        <= w_pred;
            r_is_jalr     <= w_is_jalr;
            r_drop        <= w_drop;
            r_icache_req  <= w_icache_req;
            r_icache_addr <= w_icache_addr;
            r_ask         <= w_ask;
            r_now_addr    <= w_now_addr;
            r_jump_addr   <= w_jump_addr;
            r_next_addr   <= w_next_addr;
            r_ins_valid   <= w_ins_valid;
            r_ins_out     <= w_ins_out;
            r_ins_pc      <= w_ins_pc;
            r_ins_pred    <= w_ins_pred;
        end
    end

    assign icache_req        = r_icache_req;
    assign icache_addr       = r_icache_addr;
    assign ask_predictor     = r_ask;
    assign now_ins_addr      = r_now_addr;
    assign jump_addr_from_if = r_jump_addr;
    assign next_addr_from_if = r_next_addr;
    assign ins_valid         = r_ins_valid;
    assign ins_out           = r_ins_out;
    assign ins_pc            = r_ins_pc;
    assign ins_pred_jump     = r_ins_pred;

endmodule
`default_nettype wire

// File: tb/tb_ins_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_ins_fetcher
// Brief    : Self-checking bench for ins_fetcher. A transaction-level model
//            tracks the program counter and predicts every fetch address,
//            predictor query and issued instruction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ins_fetcher;

    localparam logic [31:0] c_RESET_PC = 32'h0;
    localparam int          c_TIMEOUT  = 60;
    localparam int          K_ALU      = 0;
    localparam int          K_BR       = 1;
    localparam int          K_JAL      = 2;
    localparam int          K_JALR     = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        icache_rdy;
    logic [31:0] icache_ins;
    logic        jump;
    logic        predictor_sgn_rdy;
    logic        predictor_full;
    logic        if_flush;
    logic [31:0] addr_to_if;
    logic        jalr_done;
    logic [31:0] jalr_target;
    logic        dec_full;
    wire logic        icache_req;
    wire logic [31:0] icache_addr;
    wire logic        ask_predictor;
    wire logic [31:0] now_ins_addr;
    wire logic [31:0] jump_addr_from_if;
    wire logic [31:0] next_addr_from_if;
    wire logic        ins_valid;
    wire logic [31:0] ins_out;
    wire logic [31:0] ins_pc;
    wire logic        ins_pred_jump;

    int          checks = 0;
    int          errors = 0;
    int          ask_count = 0;
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    ins_fetcher #(.RESET_PC(c_RESET_PC)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_rdy(icache_rdy), .icache_ins(icache_ins),
        .ask_predictor(ask_predictor), .now_ins_addr(now_ins_addr),
        .jump_addr_from_if(jump_addr_from_if), .next_addr_from_if(next_addr_from_if),
        .jump(jump), .predictor_sgn_rdy(predictor_sgn_rdy), .predictor_full(predictor_full),
        .if_flush(if_flush), .addr_to_if(addr_to_if),
        .jalr_done(jalr_done), .jalr_target(jalr_target),
        .dec_full(dec_full),
        .ins_valid(ins_valid), .ins_out(ins_out), .ins_pc(ins_pc),
        .ins_pred_jump(ins_pred_jump)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge (sample/drive point) and tally queries
    task automatic tick();
        @(negedge clk);
        if (ask_predictor === 1'b1) ask_count++;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return icache_req;
            1:       return ask_predictor;
            default: return ins_valid;
        endcase
    endfunction

    task automatic wait_for(input int which, output int waited);
        waited = 0;
        while (waited < c_TIMEOUT && sig(which) !== 1'b1) begin
            tick();
            waited++;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_req"},   icache_req, 0);
        chk({tag, "_addr"},  icache_addr, 0);
        chk({tag, "_ask"},   ask_predictor, 0);
        chk({tag, "_now"},   now_ins_addr, 0);
        chk({tag, "_jaddr"}, jump_addr_from_if, 0);
        chk({tag, "_naddr"}, next_addr_from_if, 0);
        chk({tag, "_valid"}, ins_valid, 0);
        chk({tag, "_ins"},   ins_out, 0);
        chk({tag, "_pc"},    ins_pc, 0);
        chk({tag, "_pred"},  ins_pred_jump, 0);
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; icache_rdy = 1'b0; icache_ins = 32'h0; jump = 1'b0;
        predictor_sgn_rdy = 1'b0; predictor_full = 1'b0; if_flush = 1'b0;
        addr_to_if = 32'h0; jalr_done = 1'b0; jalr_target = 32'h0; dec_full = 1'b0;
    endtask

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] fill);
        return {imm[12], imm[10:5], fill[24:20], fill[19:15], fill[14:12],
                imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] fill);
        return {imm[20], imm[10:1], imm[11], imm[19:12], fill[11:7], 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_other(input logic [31:0] fill, input int kind);
        logic [6:0] ops [5];
        ops = '{7'b0010011, 7'b0110011, 7'b0000011, 7'b0100011, 7'b0110111};
        if (kind == K_JALR) return {fill[31:7], 7'b1100111};
        return {fill[31:7], ops[fill[2:0] % 5]};
    endfunction

    // One fetch-to-issue transaction, with expectations from the model PC
    task automatic run_ins(input int kind, input int imm, input logic take,
                           input logic [31:0] jtgt, input int ic_lat, input int full_cyc,
                           input int pred_lat, input int stall, input int hold,
                           input string tag);
        logic [31:0] w, fill, imm_v, exp_next;
        logic        exp_pred;
        int          waited, a0;
        fill  = $urandom();
        imm_v = imm;
        case (kind)
            K_BR:    w = enc_b(imm_v, fill);
            K_JAL:   w = enc_j(imm_v, fill);
            default: w = enc_other(fill, kind);
        endcase
        case (kind)
            K_BR:    begin exp_next = take ? m_pc + imm_v : m_pc + 32'd4; exp_pred = take; end
            K_JAL:   begin exp_next = m_pc + imm_v; exp_pred = 1'b1; end
            K_JALR:  begin exp_next = jtgt; exp_pred = 1'b0; end
            default: begin exp_next = m_pc + 32'd4; exp_pred = 1'b0; end
        endcase
        a0 = ask_count;

        wait_for(0, waited);
        chk({tag, "_req_timeout"}, waited < c_TIMEOUT, 1);
        chk({tag, "_icache_addr"}, icache_addr, m_pc);
        for (int i = 0; i < ic_lat; i++) begin
            tick();
            chk({tag, "_req_held"}, icache_req, 1);
        end
        icache_rdy     = 1'b1;
        icache_ins     = w;
        predictor_full = (kind == K_BR) && (full_cyc > 0);
        dec_full       = (kind != K_BR) && (stall > 0);
        tick();
        icache_rdy = 1'b0;
        icache_ins = $urandom();
        chk({tag, "_req_drop"}, icache_req, 0);

        if (kind == K_BR) begin
            for (int i = 0; i < full_cyc; i++) begin
                tick();
                chk({tag, "_ask_while_full"}, ask_predictor, 0);
            end
            predictor_full = 1'b0;
            wait_for(1, waited);
            chk({tag, "_ask_delay"}, waited, 1);
            chk({tag, "_now_addr"}, now_ins_addr, m_pc);
            chk({tag, "_jump_addr"}, jump_addr_from_if, m_pc + imm_v);
            chk({tag, "_next_addr"}, next_addr_from_if, m_pc + 32'd4);
            tick();
            chk({tag, "_ask_one_pulse"}, ask_predictor, 0);
            for (int i = 0; i < pred_lat; i++) tick();
            predictor_sgn_rdy = 1'b1;
            jump              = take;
            dec_full          = (stall > 0);
            tick();
            predictor_sgn_rdy = 1'b0;
            jump              = $urandom_range(0, 1);
        end

        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, "_stall_valid"}, ins_valid, 0);
        end
        dec_full = 1'b0;
        if (hold > 0) begin
            rdy = 1'b0;
            for (int i = 0; i < hold; i++) begin
                tick();
                chk({tag, "_hold_valid"}, ins_valid, 0);
            end
            rdy = 1'b1;
        end

        wait_for(2, waited);
        chk({tag, "_valid_timeout"}, waited < c_TIMEOUT, 1);
        chk({tag, "_ins_out"}, ins_out, w);
        chk({tag, "_ins_pc"}, ins_pc, m_pc);
        chk({tag, "_pred"}, ins_pred_jump, exp_pred);
        tick();
        chk({tag, "_valid_pulse"}, ins_valid, 0);
        chk({tag, "_ask_count"}, ask_count - a0, (kind == K_BR) ? 1 : 0);

        if (kind == K_JALR) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                chk({tag, "_jalr_stall"}, icache_req, 0);
            end
            jalr_done   = 1'b1;
            jalr_target = jtgt;
            tick();
            jalr_done   = 1'b0;
        end
        m_pc = exp_next;
    endtask

    initial begin
        int waited, a0, kind, imm;
        idle_inputs();
        rst = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst  = 1'b1;
        m_pc = c_RESET_PC;

        // Straight-line, branches, JAL, JALR
        run_ins(K_ALU, 0, 1'b0, 0, 0, 0, 0, 0, 0, "addi0");
        run_ins(K_ALU, 0, 1'b0, 0, 2, 0, 0, 1, 0, "addi4");
        run_ins(K_BR, 16, 1'b0, 0, 1, 0, 1, 0, 0, "beq_nt");
        run_ins(K_BR, 12, 1'b1, 0, 0, 3, 2, 0, 0, "beq_t_full");
        run_ins(K_ALU, 0, 1'b0, 0, 0, 0, 0, 0, 2, "alu18");
        run_ins(K_ALU, 0, 1'b0, 0, 0, 0, 0, 0, 0, "alu1c");
        run_ins(K_JAL, -8, 1'b0, 0, 1, 0, 0, 0, 0, "jal_back");
        chk("jal_target_pc", m_pc, 32'h18);
        run_ins(K_JAL, 24, 1'b0, 0, 0, 0, 0, 0, 0, "jal_fwd");
        run_ins(K_JALR, 0, 1'b0, 32'h200, 0, 0, 0, 0, 0, "jalr");
        run_ins(K_JAL, -448, 1'b0, 0, 0, 0, 0, 0, 0, "jal_to_40");

        // Flush while the fetch of 0x40 is outstanding
        a0 = ask_count;
        wait_for(0, waited);
        chk("flush_req_timeout", waited < c_TIMEOUT, 1);
        chk("flush_pre_addr", icache_addr, 32'h40);
        if_flush   = 1'b1;
        addr_to_if = 32'h100;
        tick();
        if_flush = 1'b0;
        chk("flush_req_drop", icache_req, 0);
        chk("flush_no_ask", ask_predictor, 0);
        tick();
        chk("flush_drop_wait", icache_req, 0);
        icache_rdy = 1'b1;
        icache_ins = 32'h00000063;
        tick();
        icache_rdy = 1'b0;
        chk("flush_stale_valid", ins_valid, 0);
        m_pc = 32'h100;
        run_ins(K_ALU, 0, 1'b0, 0, 0, 0, 0, 0, 0, "after_flush");
        chk("flush_ask_count", ask_count - a0, 0);

        // Asynchronous reset while waiting for the predictor answer
        wait_for(0, waited);
        chk("rstpred_addr", icache_addr, 32'h104);
        icache_rdy = 1'b1;
        icache_ins = enc_b(32'd32, 32'h0);
        tick();
        icache_rdy = 1'b0;
        wait_for(1, waited);
        chk("rstpred_ask", ask_predictor, 1);
        tick();
        #2 rst = 1'b0;
        #1 check_outputs_zero("async_rst");
        tick();
        idle_inputs();
        rst  = 1'b1;
        m_pc = c_RESET_PC;
        run_ins(K_ALU, 0, 1'b0, 0, 0, 0, 0, 0, 0, "post_rst");

        // Randomized program flow against the model PC
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            kind = (kind < 4) ? K_ALU : (kind < 7) ? K_BR : (kind < 9) ? K_JAL : K_JALR;
            imm  = (int'($urandom_range(0, 32)) - 16) * 4;
            run_ins(kind, imm, 1'($urandom_range(0, 1)), $urandom() & 32'h0000FFFC,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 2), $urandom_range(0, 1), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
